// File: rtl/control_multiplexado_display_pkg.sv
// Shared state encoding and anode constants for the two-digit display scheduler.
package control_multiplexado_display_pkg;

    typedef enum logic [1:0] {
        BLANK0 = 2'd0,
        SHOW0  = 2'd1,
        BLANK1 = 2'd2,
        SHOW1  = 2'd3
    } estado_t;

    localparam logic [1:0] ANODOS_OFF = 2'b11;
    localparam logic [1:0] ANODO0_ON  = 2'b10;
    localparam logic [1:0] ANODO1_ON  = 2'b01;

    // Active-low anode pattern lit in a given state.
    function automatic logic [1:0] anodos_de(input estado_t e);
        case (e)
            SHOW0:   return ANODO0_ON;
            SHOW1:   return ANODO1_ON;
            default: return ANODOS_OFF;
        endcase
    endfunction

    // Mux select for a given state; it flips in BLANK1/BLANK0 so the mux settles dark.
    function automatic logic seleccion_de(input estado_t e);
        return (e == BLANK1) || (e == SHOW1);
    endfunction

endpackage

// File: rtl/control_multiplexado_display_contador_ranura.sv
// Slot counter: counts while enabled, clears on request, flags when it reaches the limit.
module contador_ranura
    import control_multiplexado_display_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_en,
    input  logic                 i_clr,
    input  logic [DIV_WIDTH-1:0] i_limite,
    output logic                 o_fin
);

    logic [DIV_WIDTH-1:0] r_cuenta;

    // Count register; frozen whenever i_en is low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cuenta <= '0;
        end else if (i_en) begin
            if (i_clr) begin
                r_cuenta <= '0;
            end else begin
                r_cuenta <= r_cuenta + 1'b1;
            end
        end
    end

    assign o_fin = (r_cuenta == i_limite);

endmodule

// File: rtl/control_multiplexado_display.sv
// Two-digit time-multiplexing scheduler with blanking gaps and frame-aligned digit updates.
module control_multiplexado_display
    import control_multiplexado_display_pkg::*;
#(
    parameter int unsigned DIV_WIDTH     = 16,
    parameter int unsigned REFRESH_COUNT = 50000,
    parameter int unsigned BLANK_COUNT   = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] D1_in,
    input  logic [3:0] D0_in,
    input  logic       actualizar,
    output logic       Seleccion,
    output logic [3:0] D1,
    output logic [3:0] D0,
    output logic [1:0] anodos,
    output logic       fin_ciclo,
    output logic       pendiente
);

    localparam logic [DIV_WIDTH-1:0] LIM_SHOW  = DIV_WIDTH'(REFRESH_COUNT - 1);
    localparam logic [DIV_WIDTH-1:0] LIM_BLANK = DIV_WIDTH'(BLANK_COUNT - 1);

    estado_t              r_estado;
    estado_t              w_estado_sig;
    logic [DIV_WIDTH-1:0] w_limite;
    logic                 w_tc;
    logic                 w_avanza;
    logic                 w_frontera;

    logic [3:0] r_d1, r_d0, r_h1, r_h0;
    logic [3:0] w_d1_sig, w_d0_sig;
    logic       r_pend, w_pend_sig;
    logic [1:0] r_anodos;
    logic       r_sel;
    logic       r_fin;

    assign w_limite = ((r_estado == SHOW0) || (r_estado == SHOW1)) ? LIM_SHOW : LIM_BLANK;
    assign w_avanza = enable && w_tc;

    contador_ranura #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_contador (
        .clk      (clk),
        .reset    (reset),
        .i_en     (enable),
        .i_clr    (w_tc),
        .i_limite (w_limite),
        .o_fin    (w_tc)
    );

    // Next state, frame boundary detection and frame-aligned digit/pending update.
    always_comb begin
        w_estado_sig = r_estado;
        w_frontera   = 1'b0;
        w_d1_sig     = r_d1;
        w_d0_sig     = r_d0;
        w_pend_sig   = r_pend;

        if (w_avanza) begin
            unique case (r_estado)
                BLANK0: w_estado_sig = SHOW0;
                SHOW0:  w_estado_sig = BLANK1;
                BLANK1: w_estado_sig = SHOW1;
                SHOW1: begin
                    w_estado_sig = BLANK0;
                    w_frontera   = 1'b1;
                end
            endcase
        end

        if (w_frontera) begin
            // A strobe landing on the boundary bypasses the holding registers.
            if (actualizar) begin
                w_d1_sig = D1_in;
                w_d0_sig = D0_in;
            end else if (r_pend) begin
                w_d1_sig = r_h1;
                w_d0_sig = r_h0;
            end
            w_pend_sig = 1'b0;
        end else if (actualizar) begin
            w_pend_sig = 1'b1;
        end
    end

    // State and registered outputs; outputs are decoded from the next state so they line up.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_estado <= BLANK0;
            r_anodos <= ANODOS_OFF;
            r_sel    <= 1'b0;
            r_fin    <= 1'b0;
            r_d1     <= 4'h0;
            r_d0     <= 4'h0;
            r_h1     <= 4'h0;
            r_h0     <= 4'h0;
            r_pend   <= 1'b0;
        end else begin
            r_estado <= w_estado_sig;
            r_anodos <= enable ? anodos_de(w_estado_sig) : ANODOS_OFF;
            r_sel    <= seleccion_de(w_estado_sig);
            r_fin    <= w_frontera;
            r_d1     <= w_d1_sig;
            r_d0     <= w_d0_sig;
            r_pend   <= w_pend_sig;
            if (actualizar) begin
                r_h1 <= D1_in;
                r_h0 <= D0_in;
            end
        end
    end

    assign Seleccion = r_sel;
    assign D1        = r_d1;
    assign D0        = r_d0;
    assign anodos    = r_anodos;
    assign fin_ciclo = r_fin;
    assign pendiente = r_pend;

endmodule

// File: doc/control_multiplexado_display.md
Name: control_multiplexado_display

Overview:
Time-division scheduler that shares the 4-bit 2:1 digit multiplexer and its single 7-segment decode path between two display digits. It sequences the mux select, drives the two active-low digit anodes, and inserts a blanking gap between digits to prevent ghosting. New digit values are held and applied only at frame boundaries, so a displayed frame never tears. It sits between the BCD/counter logic (data producers) and the mux + 7-segment decoder.

Parameters:
DIV_WIDTH, 16, width of the slot counter
REFRESH_COUNT, 50000, clk cycles each digit is lit (>=1, < 2**DIV_WIDTH)
BLANK_COUNT, 500, clk cycles both anodes off before each digit (>=1, < 2**DIV_WIDTH)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
enable  input  1  1 = run scheduler; 0 = freeze state/counter, anodes off
D1_in  input  4  new value for digit 1
D0_in  input  4  new value for digit 0
actualizar  input  1  one-cycle strobe: capture D1_in/D0_in for next frame
Seleccion  output  1  mux select (0 = D0, 1 = D1), registered
D1  output  4  frame-stable digit 1 value to mux input D1, registered
D0  output  4  frame-stable digit 0 value to mux input D0, registered
anodos  output  2  active-low digit enables, [0] = digit 0, [1] = digit 1, registered
fin_ciclo  output  1  one-cycle pulse at each frame boundary
pendiente  output  1  captured update waiting for next frame boundary

Behaviour:
- Reset (reset==0 at clk edge): state BLANK0, counter 0, Seleccion 0, anodos 2'b11, D1/D0 4'h0, holding regs 4'h0, fin_ciclo 0, pendiente 0. Reset wins over every other input, including mid-frame.
- FSM states: BLANK0 -> SHOW0 -> BLANK1 -> SHOW1 -> BLANK0.
- Counter counts 0..N-1 in each state (N = BLANK_COUNT for BLANKx, REFRESH_COUNT for SHOWx); on count==N-1 with enable=1: next state, counter <- 0.
- Outputs per state (registered, valid in the same cycle as the state): BLANK0: anodos 11, Seleccion 0. SHOW0: anodos 10, Seleccion 0. BLANK1: anodos 11, Seleccion 1. SHOW1: anodos 01, Seleccion 1. Select changes only during blanking; the mux output is settled before the anode turns on.
- Frame = 2*(BLANK_COUNT+REFRESH_COUNT) cycles. The SHOW1 -> BLANK0 transition is the frame boundary: fin_ciclo=1 for exactly the first BLANK0 cycle.
- Update handshake: actualizar=1 -> holding regs <- D1_in/D0_in, pendiente <- 1 (next cycle). On the frame boundary with pendiente=1: D1/D0 <- holding, pendiente <- 0. Multiple strobes within one frame: last one wins.
- actualizar in the same cycle as the boundary transition: D1/D0 load D1_in/D0_in directly, holding updated, pendiente stays 0.
- Between boundaries D1/D0 never change.
- enable=0: state, counter, Seleccion, D1/D0 held; anodos forced 11; fin_ciclo 0; actualizar still captured. enable back to 1: resume from the held state/count, with no extra cycle.

Decomposition:
- Shared package: state encoding constants (BLANK0=2'd0, SHOW0=2'd1, BLANK1=2'd2, SHOW1=2'd3), anode constants ANODOS_OFF=2'b11, ANODO0_ON=2'b10, ANODO1_ON=2'b01.
- One sub-module: contador_ranura (DIV_WIDTH-bit counter with enable, sync clear, terminal-count output compared against a limit input). FSM, anode decode and update latching stay in the top.

Test Plan (REFRESH_COUNT=4, BLANK_COUNT=2, frame 12 cycles):
1. Hold reset=0 for 3 cycles, then release with enable=1 -> anodos 11, Seleccion 0, D1/D0 0. Then 2 cycles at 11/sel0, 4 at 10/sel0, 2 at 11/sel1, 4 at 01/sel1. fin_ciclo high on cycle 12 after release, then every 12 cycles.
2. Pulse actualizar in the 4th cycle of the frame with D1_in=4'h7, D0_in=4'h3 -> pendiente=1 from the next cycle. D1/D0 unchanged until the boundary, then 7/3 in the fin_ciclo cycle; pendiente=0.
3. Two strobes in one frame (9/1, then 5/2) -> only 5/2 applied at the boundary.
4. Strobe coincident with the SHOW1->BLANK0 transition (D1_in=A, D0_in=B) -> D1/D0 = A/B in the fin_ciclo cycle; pendiente never asserts.
5. enable=0 for 5 cycles in the middle of SHOW0 -> anodos 11, counter/state frozen. After re-enable, SHOW0 completes its remaining cycles; frame length is 12+5 cycles.
6. Assert reset=0 for 1 cycle in the middle of SHOW1 with an update pending -> next cycle: BLANK0, anodos 11, D1/D0 0, pendiente 0, no fin_ciclo.
